// File: rtl/lighting_command_generator.sv
// Push-button / presence-sensor front end: synchronizes and debounces both raw
// inputs, then classifies them into one-cycle command pulses a/b/c/d.
module lighting_command_generator #(
  parameter int DEBOUNCE_CYC     = 4,
  parameter int LONG_PRESS_CYC   = 20,
  parameter int IDLE_TIMEOUT_CYC = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic presence_sensor,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYC + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LIM   = DB_W'(DEBOUNCE_CYC);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(LONG_PRESS_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(IDLE_TIMEOUT_CYC);

  typedef enum logic [1:0] {
    BTN_IDLE    = 2'd0,
    BTN_PRESSED = 2'd1,
    BTN_LONG    = 2'd2
  } btn_state_t;

  typedef enum logic [1:0] {
    VACANT   = 2'd0,
    OCCUPIED = 2'd1,
    TIMING   = 2'd2
  } pres_state_t;

  logic btn_sync1_q, btn_sync1_d, btn_sync2_q, btn_sync2_d;
  logic prs_sync1_q, prs_sync1_d, prs_sync2_q, prs_sync2_d;

  logic            btn_lvl_q, btn_lvl_d;
  logic [DB_W-1:0] btn_cnt_q, btn_cnt_d, btn_cnt_inc;
  logic            prs_lvl_q, prs_lvl_d;
  logic [DB_W-1:0] prs_cnt_q, prs_cnt_d, prs_cnt_inc;

  btn_state_t        btn_state_q, btn_state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  pres_state_t       prs_state_q, prs_state_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d, idle_cnt_inc;

  logic a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

  // Stage 0: two-flop synchronizers
  always_comb begin
    btn_sync1_d = push_button;
    btn_sync2_d = btn_sync1_q;
    prs_sync1_d = presence_sensor;
    prs_sync2_d = prs_sync1_q;
  end

  // Stage 1: debounce; the level flips on the DEBOUNCE_CYC-th consecutive
  // cycle of disagreement, any agreement restarts the count.
  always_comb begin
    btn_cnt_inc = btn_cnt_q + DB_W'(1);
    btn_lvl_d   = btn_lvl_q;
    btn_cnt_d   = '0;
    if (btn_sync2_q != btn_lvl_q) begin
      if (btn_cnt_inc == DB_LIM) begin
        btn_lvl_d = btn_sync2_q;
      end else begin
        btn_cnt_d = btn_cnt_inc;
      end
    end
  end

  always_comb begin
    prs_cnt_inc = prs_cnt_q + DB_W'(1);
    prs_lvl_d   = prs_lvl_q;
    prs_cnt_d   = '0;
    if (prs_sync2_q != prs_lvl_q) begin
      if (prs_cnt_inc == DB_LIM) begin
        prs_lvl_d = prs_sync2_q;
      end else begin
        prs_cnt_d = prs_cnt_inc;
      end
    end
  end

  // Stage 2: press classification; a press ends in exactly one of a or b
  always_comb begin
    btn_state_d = btn_state_q;
    hold_cnt_d  = hold_cnt_q;
    a_d         = 1'b0;
    b_d         = 1'b0;
    case (btn_state_q)
      BTN_IDLE: begin
        if (btn_lvl_q) begin
          btn_state_d = BTN_PRESSED;
          hold_cnt_d  = HOLD_W'(1);
        end
      end
      BTN_PRESSED: begin
        if (hold_cnt_q >= HOLD_LIM) begin
          a_d         = 1'b1;
          hold_cnt_d  = '0;
          btn_state_d = btn_lvl_q ? BTN_LONG : BTN_IDLE;
        end else if (!btn_lvl_q) begin
          b_d         = 1'b1;
          hold_cnt_d  = '0;
          btn_state_d = BTN_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      BTN_LONG: begin
        if (!btn_lvl_q) begin
          btn_state_d = BTN_IDLE;
        end
      end
      default: begin
        btn_state_d = BTN_IDLE;
        hold_cnt_d  = '0;
      end
    endcase
  end

  // Stage 2: occupancy tracking; c and d come from exclusive branches
  always_comb begin
    prs_state_d  = prs_state_q;
    idle_cnt_inc = idle_cnt_q + IDLE_W'(1);
    idle_cnt_d   = idle_cnt_q;
    c_d          = 1'b0;
    d_d          = 1'b0;
    case (prs_state_q)
      VACANT: begin
        if (prs_lvl_q) begin
          d_d         = 1'b1;
          prs_state_d = OCCUPIED;
        end
      end
      OCCUPIED: begin
        if (!prs_lvl_q) begin
          prs_state_d = TIMING;
          idle_cnt_d  = '0;
        end
      end
      TIMING: begin
        if (prs_lvl_q) begin
          d_d         = 1'b1;
          idle_cnt_d  = '0;
          prs_state_d = OCCUPIED;
        end else if (idle_cnt_inc == IDLE_LIM) begin
          c_d         = 1'b1;
          idle_cnt_d  = '0;
          prs_state_d = VACANT;
        end else begin
          idle_cnt_d = idle_cnt_inc;
        end
      end
      default: begin
        prs_state_d = VACANT;
        idle_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_sync1_q <= 1'b0;
      btn_sync2_q <= 1'b0;
      prs_sync1_q <= 1'b0;
      prs_sync2_q <= 1'b0;
      btn_lvl_q   <= 1'b0;
      btn_cnt_q   <= '0;
      prs_lvl_q   <= 1'b0;
      prs_cnt_q   <= '0;
      btn_state_q <= BTN_IDLE;
      hold_cnt_q  <= '0;
      prs_state_q <= VACANT;
      idle_cnt_q  <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      d_q         <= 1'b0;
    end else begin
      btn_sync1_q <= btn_sync1_d;
      btn_sync2_q <= btn_sync2_d;
      prs_sync1_q <= prs_sync1_d;
      prs_sync2_q <= prs_sync2_d;
      btn_lvl_q   <= btn_lvl_d;
      btn_cnt_q   <= btn_cnt_d;
      prs_lvl_q   <= prs_lvl_d;
      prs_cnt_q   <= prs_cnt_d;
      btn_state_q <= btn_state_d;
      hold_cnt_q  <= hold_cnt_d;
      prs_state_q <= prs_state_d;
      idle_cnt_q  <= idle_cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;

endmodule

// File: tb/tb_lighting_command_generator.sv
// Directed bench for lighting_command_generator at default parameters;
// inputs change 2 ns after a rising edge, outputs are checked at that point.
module tb_lighting_command_generator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push_button = 1'b0;
  logic presence_sensor = 1'b0;
  logic a, b, c, d;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_d = 0;
  int base_a, base_b, base_c, base_d;

  lighting_command_generator dut (
    .clk             (clk),
    .rst             (rst),
    .push_button     (push_button),
    .presence_sensor (presence_sensor),
    .a               (a),
    .b               (b),
    .c               (c),
    .d               (d)
  );

  always #5 clk = ~clk;

  // Running pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (a === 1'b1) cnt_a <= cnt_a + 1;
    if (b === 1'b1) cnt_b <= cnt_b + 1;
    if (c === 1'b1) cnt_c <= cnt_c + 1;
    if (d === 1'b1) cnt_d <= cnt_d + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_a = cnt_a;
    base_b = cnt_b;
    base_c = cnt_c;
    base_d = cnt_d;
  endtask

  initial begin
    // Reset state with both inputs low
    #1;
    chk("rst_a", a, 1'b0);
    chk("rst_b", b, 1'b0);
    chk("rst_c", c, 1'b0);
    chk("rst_d", d, 1'b0);
    step(3);
    rst = 1'b0;
    snap();
    step(100);
    chk("idle_a_cnt", cnt_a - base_a, 0);
    chk("idle_b_cnt", cnt_b - base_b, 0);
    chk("idle_c_cnt", cnt_c - base_c, 0);
    chk("idle_d_cnt", cnt_d - base_d, 0);

    // Short press: 10 cycles high, b 7 cycles after the release
    snap();
    push_button = 1'b1;
    step(10);
    push_button = 1'b0;
    step(6);
    chk("short_b_early", b, 1'b0);
    step(1);
    chk("short_b_pulse", b, 1'b1);
    chk("short_a_quiet", a, 1'b0);
    step(1);
    chk("short_b_end", b, 1'b0);
    step(20);
    chk("short_b_cnt", cnt_b - base_b, 1);
    chk("short_a_cnt", cnt_a - base_a, 0);

    // Long press: 30 cycles high, a when the hold count reaches 20, no b
    snap();
    push_button = 1'b1;
    step(26);
    chk("long_a_early", a, 1'b0);
    step(1);
    chk("long_a_pulse", a, 1'b1);
    chk("long_b_quiet", b, 1'b0);
    step(1);
    chk("long_a_end", a, 1'b0);
    step(2);
    push_button = 1'b0;
    step(20);
    chk("long_a_cnt", cnt_a - base_a, 1);
    chk("long_b_cnt", cnt_b - base_b, 0);

    // Chatter every cycle, then a 3-cycle glitch: both filtered out
    snap();
    for (int i = 0; i < 20; i++) begin
      push_button = ~push_button;
      step(1);
    end
    push_button = 1'b0;
    step(20);
    push_button = 1'b1;
    step(3);
    push_button = 1'b0;
    step(20);
    chk("bounce_a_cnt", cnt_a - base_a, 0);
    chk("bounce_b_cnt", cnt_b - base_b, 0);

    // Presence start, then vacancy 50 idle cycles after the debounced fall
    presence_sensor = 1'b1;
    step(6);
    chk("pres_d_early", d, 1'b0);
    step(1);
    chk("pres_d_pulse", d, 1'b1);
    step(1);
    chk("pres_d_end", d, 1'b0);
    step(10);
    snap();
    presence_sensor = 1'b0;
    step(56);
    chk("vac_c_early", c, 1'b0);
    step(1);
    chk("vac_c_pulse", c, 1'b1);
    chk("vac_d_quiet", d, 1'b0);
    step(1);
    chk("vac_c_end", c, 1'b0);
    chk("vac_c_cnt", cnt_c - base_c, 1);

    // Re-occupied 20 cycles into the timeout: second d, no c
    presence_sensor = 1'b1;
    step(7);
    chk("reocc_d1", d, 1'b1);
    step(10);
    snap();
    presence_sensor = 1'b0;
    step(20);
    presence_sensor = 1'b1;
    step(6);
    chk("reocc_d2_early", d, 1'b0);
    step(1);
    chk("reocc_d2_pulse", d, 1'b1);
    chk("reocc_c_quiet", c, 1'b0);
    step(80);
    chk("reocc_c_cnt", cnt_c - base_c, 0);
    chk("reocc_d_cnt", cnt_d - base_d, 1);

    // Reset while a press is held and vacancy is timing: nothing survives
    presence_sensor = 1'b0;
    push_button = 1'b1;
    step(16);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_a", a, 1'b0);
    chk("mid_rst_b", b, 1'b0);
    chk("mid_rst_c", c, 1'b0);
    chk("mid_rst_d", d, 1'b0);
    push_button = 1'b0;
    step(3);
    rst = 1'b0;
    snap();
    step(100);
    chk("post_rst_a_cnt", cnt_a - base_a, 0);
    chk("post_rst_b_cnt", cnt_b - base_b, 0);
    chk("post_rst_c_cnt", cnt_c - base_c, 0);
    chk("post_rst_d_cnt", cnt_d - base_d, 0);

    // Inputs held high through reset release: fresh presence and fresh press
    rst = 1'b1;
    presence_sensor = 1'b1;
    push_button = 1'b1;
    step(3);
    rst = 1'b0;
    step(6);
    chk("held_d_early", d, 1'b0);
    chk("held_b_early", b, 1'b0);
    step(1);
    chk("held_d_pulse", d, 1'b1);
    step(5);
    push_button = 1'b0;
    step(6);
    chk("held_b_before", b, 1'b0);
    step(1);
    chk("held_b_pulse", b, 1'b1);
    chk("held_a_quiet", a, 1'b0);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lighting_command_generator.md
Name: lighting_command_generator

Overview:
- Front end for the lighting control FSM: turns one raw push-button and one raw presence sensor into the one-cycle command pulses that FSM consumes.
- Pulse mapping:
  - a: mode toggle, on a long press.
  - b: lamp on/off toggle, on a short press.
  - c: vacancy timeout.
  - d: presence detected.
- Sits between board pins and the lighting FSM, in the same clk/rst domain.

Parameters:
- DEBOUNCE_CYC, 4: consecutive synchronized cycles a raw input must hold a new level before the debounced level changes (>=1).
- LONG_PRESS_CYC, 20: debounced-high cycles that classify a press as long (>=2).
- IDLE_TIMEOUT_CYC, 50: debounced-low presence cycles before vacancy is declared (>=1).

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- push_button, input, 1: raw, asynchronous, bouncy; 1 = pressed.
- presence_sensor, input, 1: raw, asynchronous; 1 = occupant detected.
- a, output, 1: one-cycle pulse, mode toggle (long press).
- b, output, 1: one-cycle pulse, lamp toggle (short press).
- c, output, 1: one-cycle pulse, vacancy timeout.
- d, output, 1: one-cycle pulse, presence start.

Behaviour:
- Reset: all outputs, synchronizer flops, debounced levels and counters = 0; button FSM = BTN_IDLE; presence FSM = VACANT. Clearing is asynchronous on rst rise; normal operation resumes on the first clk edge after rst falls.
- Synchronizer: 2-flop per raw input, 2 cycles latency.
- Debounce (one instance per input):
  - Counter increments while the synced level differs from the debounced level; clears to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYC, the debounced level takes the synced level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles never propagate.
- Outputs are registered: each pulse asserts the cycle after its debounced event and is high exactly 1 cycle.
- Latency raw edge -> pulse = 2 + DEBOUNCE_CYC + 1 cycles (7 at defaults).
- Button FSM:
  - BTN_IDLE -> BTN_PRESSED on debounced rise; hold_cnt = 1.
  - BTN_PRESSED: hold_cnt increments each cycle the debounced level stays high (saturates). On debounced fall while hold_cnt < LONG_PRESS_CYC: pulse b, -> BTN_IDLE.
  - When hold_cnt reaches LONG_PRESS_CYC: pulse a, -> BTN_LONG.
  - BTN_LONG -> BTN_IDLE on debounced fall, with no pulse. Each press yields exactly one of a or b, never both.
- Presence FSM:
  - VACANT -> OCCUPIED on debounced rise: pulse d.
  - OCCUPIED -> TIMING on debounced fall; idle_cnt = 0.
  - TIMING: idle_cnt increments each cycle. At IDLE_TIMEOUT_CYC: pulse c, -> VACANT, idle_cnt = 0.
  - TIMING -> OCCUPIED on debounced rise before timeout: pulse d, idle_cnt cleared, no c.
- c and d are never asserted in the same cycle. a/b may coincide with c/d; both FSMs are independent.
- Counter widths are $clog2(param+1). Counters saturate and never wrap.
- Reset mid-operation: an in-progress press or timeout is dropped with no pulse. A button held through reset release is seen as a new press once debounced.
- Presence high at reset release produces d after the normal latency.

Test Plan:
- Reset with both inputs low, then 100 idle cycles -> a=b=c=d=0 throughout, no spurious pulse.
- push_button high 10 cycles then low (defaults) -> exactly one b pulse, 7 cycles after the raw fall edge; no a pulse.
- push_button high 30 cycles -> a pulse 1 cycle after debounced-high count hits 20; release -> no b pulse.
- push_button toggling every cycle for 20 cycles, then low -> no pulses. A 3-cycle high glitch -> no pulses.
- Presence scenario:
  - presence_sensor rises -> d pulse 7 cycles later.
  - presence_sensor falls -> c pulse 50 cycles after the debounced fall.
  - Repeat, re-raising presence after 20 low cycles -> second d pulse, no c.
- Assert rst during BTN_PRESSED (hold 10) and during TIMING -> all outputs 0 immediately. After release, with both inputs low -> no a/b/c pulse.
